// File: rtl/bconv_window_sequencer.sv
// bconv_window_sequencer
// Walks a K_H x K_W window across a captured binary feature map in raster
// order, feeds each window to an external XNOR/popcount unit, thresholds the
// popcount it returns and assembles the output map.
//
// Run timeline (E0 = the edge that accepts start):
//   cycle 0       LOAD : window(0,0) is being prepared
//   cycles 1..N   RUN  : window_o shows position p = cycle-1, popcount_i answers
//   cycle N+1     DONE : layer_o holds the new map, done is high
module bconv_window_sequencer #(
  parameter int INPUT_H  = 28,
  parameter int INPUT_W  = 28,
  parameter int K_H      = 3,
  parameter int K_W      = 3,
  parameter int OUTPUT_H = INPUT_H - K_H + 1,
  parameter int OUTPUT_W = INPUT_W - K_W + 1,
  parameter int PC_W     = $clog2(K_H * K_W + 1),
  parameter int THRESH   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [INPUT_H*INPUT_W-1:0]     layer_i,
  output logic [K_H*K_W-1:0]             window_o,
  input  logic [PC_W-1:0]                popcount_i,
  output logic [OUTPUT_H*OUTPUT_W-1:0]   layer_o,
  output logic                           busy,
  output logic                           done
);

  localparam int IMG_BITS = INPUT_H * INPUT_W;
  localparam int WIN_BITS = K_H * K_W;
  localparam int N_POS    = OUTPUT_H * OUTPUT_W;

  // Index widths sized so a bit-select covers exactly the addressed vector.
  localparam int IMG_IW = (IMG_BITS > 1) ? $clog2(IMG_BITS) : 1;
  localparam int WIN_IW = (WIN_BITS > 1) ? $clog2(WIN_BITS) : 1;
  localparam int POS_W  = (N_POS > 1)    ? $clog2(N_POS)    : 1;
  localparam int ROW_W  = (OUTPUT_H > 1) ? $clog2(OUTPUT_H) : 1;
  localparam int COL_W  = (OUTPUT_W > 1) ? $clog2(OUTPUT_W) : 1;

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OUTPUT_H - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(OUTPUT_W - 1);

  // Threshold compared as an unsigned 32-bit quantity.
  localparam logic [31:0] THRESH_U = 32'(THRESH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]          state_q,  state_d;
  logic [IMG_BITS-1:0] img_q,    img_d;
  logic [WIN_BITS-1:0] window_q, window_d;
  logic [ROW_W-1:0]    row_q,    row_d;
  logic [COL_W-1:0]    col_q,    col_d;
  logic [POS_W-1:0]    pos_q,    pos_d;
  logic [N_POS-1:0]    result_q, result_d;
  logic [N_POS-1:0]    layer_q,  layer_d;

  logic last_pos;
  logic hit;

  // Gather the window for output position (r,c). Kernel row kr lands in the
  // window's row K_H-1-kr, so the top image row sits in the most significant
  // window bits.
  function automatic logic [WIN_BITS-1:0] window_at(
    input logic [IMG_BITS-1:0] img,
    input logic [ROW_W-1:0]    r,
    input logic [COL_W-1:0]    c
  );
    logic [WIN_BITS-1:0] w;
    int                  idx;
    w = '0;
    for (int kr = 0; kr < K_H; kr++) begin
      for (int kc = 0; kc < K_W; kc++) begin
        idx = (int'(r) + kr) * INPUT_W + int'(c) + kc;
        w[WIN_IW'((K_H - 1 - kr) * K_W + kc)] = img[IMG_IW'(idx)];
      end
    end
    return w;
  endfunction

  // Next-state logic: capture on start, walk positions in raster order,
  // record one thresholded bit per position, publish the map at the end.
  always_comb begin
    state_d  = state_q;
    img_d    = img_q;
    window_d = window_q;
    row_d    = row_q;
    col_d    = col_q;
    pos_d    = pos_q;
    result_d = result_q;
    layer_d  = layer_q;

    last_pos = (row_q == ROW_LAST) && (col_q == COL_LAST);
    hit      = (32'(popcount_i) > THRESH_U);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          img_d   = layer_i;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        row_d    = '0;
        col_d    = '0;
        pos_d    = '0;
        window_d = window_at(img_q, '0, '0);
        state_d  = ST_RUN;
      end

      ST_RUN: begin
        result_d[pos_q] = hit;
        if (last_pos) begin
          // Publish the whole map including the bit written this cycle;
          // window_o is left on the final window.
          layer_d = result_d;
          state_d = ST_DONE;
        end else begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
          pos_d    = pos_q + 1'b1;
          window_d = window_at(img_q, row_d, col_d);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset discards any run in progress and clears the map.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      img_q    <= '0;
      window_q <= '0;
      row_q    <= '0;
      col_q    <= '0;
      pos_q    <= '0;
      result_q <= '0;
      layer_q  <= '0;
    end else begin
      state_q  <= state_d;
      img_q    <= img_d;
      window_q <= window_d;
      row_q    <= row_d;
      col_q    <= col_d;
      pos_q    <= pos_d;
      result_q <= result_d;
      layer_q  <= layer_d;
    end
  end

  assign window_o = window_q;
  assign layer_o  = layer_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_bconv_window_sequencer.sv
// Bench for bconv_window_sequencer: a default 28x28 instance (A) and a 5x5,
// THRESH=0 instance (B). Stimulus pushes expected maps/windows into queues;
// negedge monitors pop and compare whenever the DUTs present results.
module tb_bconv_window_sequencer;

  localparam int NA = 676;
  localparam int NB = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Instance A signals
  logic          start_a = 1'b0;
  logic [783:0]  layer_a = '0;
  logic [8:0]    window_a;
  logic [3:0]    popcount_a;
  logic [675:0]  layer_o_a;
  logic          busy_a, done_a;
  int            pc_mode = 0;

  // Instance B signals
  logic          start_b = 1'b0;
  logic [24:0]   layer_b = '0;
  logic [8:0]    window_b;
  logic [3:0]    popcount_b;
  logic [8:0]    layer_o_b;
  logic          busy_b, done_b;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [675:0] res_q_a[$];
  logic [8:0]   res_q_b[$];
  logic [8:0]   win_q_b[$];

  logic [675:0] prev_a = '0;
  int  cyc_a = -1, cyc_b = -1;
  int  done_cnt_a = 0, done_cnt_b = 0;
  bit  after_a = 0, after_b = 0;

  localparam logic [783:0] IMG_ONES = {784{1'b1}};
  localparam logic [675:0] MAP_ONES = {676{1'b1}};

  // Popcount model: kernel of all ones, or a forced constant for threshold tests.
  assign popcount_a = (pc_mode == 0) ? 4'($countones(window_a)) :
                      (pc_mode == 1) ? 4'd4 : 4'd5;
  assign popcount_b = 4'($countones(window_b));

  bconv_window_sequencer dut_a (
    .clk(clk), .rst(rst), .start(start_a), .layer_i(layer_a),
    .window_o(window_a), .popcount_i(popcount_a), .layer_o(layer_o_a),
    .busy(busy_a), .done(done_a)
  );

  bconv_window_sequencer #(.INPUT_H(5), .INPUT_W(5), .THRESH(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .layer_i(layer_b),
    .window_o(window_b), .popcount_i(popcount_b), .layer_o(layer_o_b),
    .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  // Single comparison point: every check goes through here.
  task automatic checkOutput(input string name, input logic [799:0] actual,
                             input logic [799:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Start a run on instance A, optionally registering its expected map.
  task automatic applyStimulus(input logic [783:0] img, input int mode,
                               input bit push, input logic [675:0] exp_map);
    @(negedge clk);
    layer_a = img;
    pc_mode = mode;
    if (push) res_q_a.push_back(exp_map);
    start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
  endtask

  // Bounded wait for the next done pulse seen by monitor A.
  task automatic waitDoneA(input string name);
    int c0;
    bit seen;
    c0 = done_cnt_a;
    seen = 0;
    for (int i = 0; i < NA + 40 && !seen; i++) begin
      @(posedge clk);
      if (done_cnt_a != c0) seen = 1;
    end
    checkOutput(name, 800'(seen), 800'(1));
    repeat (3) @(posedge clk);
  endtask

  // Monitor A: result and latency on done, map stability late in RUN.
  always @(negedge clk) begin
    logic [675:0] exp_map;
    if (after_a) begin
      checkOutput("busy_after_done_a", 800'(busy_a), 800'(0));
      checkOutput("done_one_cycle_a", 800'(done_a), 800'(0));
      after_a = 0;
    end
    if (busy_a) cyc_a++; else cyc_a = -1;
    if (busy_a && cyc_a == NA && res_q_a.size() > 0)
      checkOutput("layer_stable_run_a", 800'(layer_o_a), 800'(prev_a));
    if (done_a) begin
      done_cnt_a++;
      if (res_q_a.size() == 0) begin
        checkOutput("unexpected_done_a", 800'(1), 800'(0));
      end else begin
        exp_map = res_q_a.pop_front();
        checkOutput("layer_o_a", 800'(layer_o_a), 800'(exp_map));
        checkOutput("done_latency_a", 800'(cyc_a), 800'(NA + 1));
        prev_a  = exp_map;
        after_a = 1;
      end
    end
  end

  // Monitor B: window sequence during RUN, result and latency on done.
  always @(negedge clk) begin
    if (after_b) begin
      checkOutput("busy_after_done_b", 800'(busy_b), 800'(0));
      checkOutput("done_one_cycle_b", 800'(done_b), 800'(0));
      after_b = 0;
    end
    if (busy_b) cyc_b++; else cyc_b = -1;
    if (busy_b && cyc_b >= 1 && cyc_b <= NB) begin
      if (win_q_b.size() == 0) checkOutput("window_queue_b", 800'(0), 800'(1));
      else checkOutput("window_b", 800'(window_b), 800'(win_q_b.pop_front()));
    end
    if (done_b) begin
      done_cnt_b++;
      if (res_q_b.size() == 0) begin
        checkOutput("unexpected_done_b", 800'(1), 800'(0));
      end else begin
        checkOutput("layer_o_b", 800'(layer_o_b), 800'(res_q_b.pop_front()));
        checkOutput("done_latency_b", 800'(cyc_b), 800'(NB + 1));
        after_b = 1;
      end
    end
  end

  // Watchdog so the bench always terminates.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus.
  initial begin
    logic [8:0] exp_win [9];
    int c0;
    bit seen;
    exp_win = '{9'h004, 9'h002, 9'h001, 9'h020, 9'h010, 9'h008,
                9'h100, 9'h080, 9'h040};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_busy_a", 800'(busy_a), 800'(0));
    checkOutput("reset_done_a", 800'(done_a), 800'(0));
    checkOutput("reset_layer_a", 800'(layer_o_a), 800'(0));
    checkOutput("reset_window_a", 800'(window_a), 800'(0));
    checkOutput("reset_busy_b", 800'(busy_b), 800'(0));

    // Instance B: single pixel (2,2), windows are one-hot in raster order.
    @(negedge clk);
    layer_b = 25'h0001000;
    foreach (exp_win[i]) win_q_b.push_back(exp_win[i]);
    res_q_b.push_back(9'h1FF);
    start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    c0 = done_cnt_b;
    seen = 0;
    for (int i = 0; i < NB + 20 && !seen; i++) begin
      @(posedge clk);
      if (done_cnt_b != c0) seen = 1;
    end
    checkOutput("done_seen_b", 800'(seen), 800'(1));
    repeat (3) @(posedge clk);

    // Instance A: all ones / all zeros with a counting popcount model.
    applyStimulus(IMG_ONES, 0, 1, MAP_ONES);
    waitDoneA("done_seen_ones");
    applyStimulus('0, 0, 1, '0);
    waitDoneA("done_seen_zeros");

    // Threshold boundary: popcount 4 never fires, 5 always fires.
    applyStimulus(IMG_ONES, 1, 1, '0);
    waitDoneA("done_seen_pc4");
    applyStimulus('0, 2, 1, MAP_ONES);
    waitDoneA("done_seen_pc5");

    // Start and input changes during RUN must not affect the run.
    applyStimulus(IMG_ONES, 0, 1, MAP_ONES);
    repeat (50) @(posedge clk);
    @(negedge clk);
    layer_a = '0;
    start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    waitDoneA("done_seen_midrun");
    repeat (NA + 10) @(posedge clk);
    checkOutput("no_second_run", 800'(busy_a), 800'(0));

    // Reset in cycle 200 of a run discards everything.
    applyStimulus(IMG_ONES, 0, 0, '0);
    repeat (200) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    prev_a = '0;
    checkOutput("abort_busy", 800'(busy_a), 800'(0));
    checkOutput("abort_done", 800'(done_a), 800'(0));
    checkOutput("abort_layer", 800'(layer_o_a), 800'(0));
    checkOutput("abort_window", 800'(window_a), 800'(0));
    repeat (2) @(posedge clk);

    // Fresh run after the abort completes normally.
    applyStimulus(IMG_ONES, 0, 1, MAP_ONES);
    waitDoneA("done_seen_after_reset");

    checkOutput("scoreboard_empty_a", 800'(res_q_a.size()), 800'(0));
    checkOutput("scoreboard_empty_b", 800'(res_q_b.size()), 800'(0));
    checkOutput("window_queue_empty_b", 800'(win_q_b.size()), 800'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/bconv_window_sequencer.md
Name: bconv_window_sequencer

Overview:
- Controller that sequences the binary-convolution datapath over one image.
- Captures an INPUT_H x INPUT_W binary feature map on start.
- Walks the K_H x K_W sliding window in raster order and presents one window per cycle to an external XNOR_POPCOUNT instance.
- Thresholds the returned popcount into one output bit per position, assembles the OUTPUT_H x OUTPUT_W map, then pulses done. Sits between the layer buffer and the XNOR/popcount unit inside the BNN conv layer.

Parameters:
- INPUT_H, 28, input map rows
- INPUT_W, 28, input map columns
- K_H, 3, kernel rows
- K_W, 3, kernel columns
- OUTPUT_H, INPUT_H-K_H+1, output rows (valid convolution, stride 1)
- OUTPUT_W, INPUT_W-K_W+1, output columns
- PC_W, $clog2(K_H*K_W+1), popcount width (4 at default)
- THRESH, 4, output bit = 1 iff popcount > THRESH (default equals 2*pc > 9 rule)

Ports:
- clk, in, 1, sole clock, rising edge
- rst, in, 1, synchronous active-high reset
- start, in, 1, request to process layer_i; sampled only in IDLE
- layer_i, in, INPUT_H*INPUT_W, flat input map; pixel (r,c) at bit r*INPUT_W+c
- window_o, out, K_H*K_W, registered window to XNOR_POPCOUNT input_feat
- popcount_i, in, PC_W, combinational popcount returned for current window_o
- layer_o, out, OUTPUT_H*OUTPUT_W, result map; bit p=r*OUTPUT_W+c
- busy, out, 1, high whenever state != IDLE
- done, out, 1, one-cycle pulse when layer_o holds a fresh result

Behaviour:
- Reset: state=IDLE, window_o=0, layer_o=0, busy=0, done=0, row/col counters=0, internal image and result registers=0. Reset wins over every other event, including mid-RUN; the partial result is discarded.
- Window mapping for output position (r,c): window_o[(K_H-1-kr)*K_W+kc] = img[(r+kr)*INPUT_W + c+kc], with kr in 0..K_H-1 and kc in 0..K_W-1.
- Edge numbering: E0 is the edge sampling start=1 in IDLE. Cycle k follows edge Ek. N = OUTPUT_H*OUTPUT_W.
- FSM states and transitions:
  - IDLE: on start, capture layer_i into img_q, go to LOAD. Otherwise hold; layer_o is held.
  - LOAD (cycle 0): at E1, window_o <= window(0,0), row=col=0, go to RUN.
  - RUN (cycles 1..N): popcount_i is valid combinationally in the same cycle. At each edge, result[p] <= (popcount_i > THRESH) for the current p, then advance.
  - Counter advance: col increments; at col==OUTPUT_W-1, col wraps to 0 and row increments. window_o <= window of the next position.
  - Last position (row=OUTPUT_H-1, col=OUTPUT_W-1): at E(N+1), write the last bit, copy the full result into layer_o (including that bit), go to DONE. window_o is held.
  - DONE (cycle N+1): done=1. At E(N+2), go to IDLE and drop done.
- Outputs and timing:
  - busy=1 in cycles 0..N+1.
  - done is high exactly one cycle, N+1 edges after E0 (677 at defaults). The next start is accepted at the earliest at E(N+2).
  - layer_o changes only at the E(N+1) update and on reset. It is stable during RUN and shows the previous result.
- Boundary conditions:
  - start while busy (any state other than IDLE) is ignored, with no queuing.
  - layer_i changes after E0 have no effect on the current run.
  - THRESH comparison is unsigned. popcount_i == THRESH gives 0.
  - popcount_i is ignored outside RUN.

Test Plan:
- Defaults, layer_i all ones, bench model popcount = number of ones in window_o (kernel all ones) -> every window_o = 9'h1FF; layer_o all ones; done high in exactly one cycle, 677 edges after E0; busy low after.
- Defaults, layer_i all zeros, same model -> layer_o = 0; timing identical to the all-ones case.
- INPUT 5x5, K 3x3, THRESH=0, single pixel (2,2)=1 -> cycles 1..9 show window_o one-hot at positions (r,c) with bit index (2-(2-r))*3+(2-c) = r*3+(2-c); layer_o = 9'h1FF; done 10 edges after E0.
- Threshold boundary: model returns constant 4 -> layer_o all 0. Returns constant 5 -> layer_o all 1.
- Second start pulsed during RUN, plus layer_i changed mid-run -> result matches the first capture; no second run; done pulses once.
- rst asserted at cycle 200 of a run -> next cycle shows busy=0, layer_o=0, done=0. A fresh start afterwards completes normally with correct output.
